// File: rtl/sub_bytes_unit_pkg.sv
// Shared AES definitions: state geometry, SubBytes FSM encoding and block type.
package sub_bytes_unit_pkg;

    localparam int unsigned AES_STATE_W = 128;
    localparam int unsigned AES_BYTES   = 16;
    localparam int unsigned BYTE_W      = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    // Byte 0 sits in the most significant lane, i.e. block[AES_BYTES-1].
    typedef logic [AES_BYTES-1:0][BYTE_W-1:0] aes_block_t;

    function automatic logic legal_bpc(input int unsigned bpc);
        return (bpc == 1) || (bpc == 2) || (bpc == 4) || (bpc == 8) || (bpc == 16);
    endfunction

endpackage

// File: rtl/sub_bytes_unit_s_box.sv
// Forward AES S-box, purely combinational 256-entry lookup.
module s_box (
    input  logic [7:0] inputValue,
    output logic [7:0] outputValue
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign outputValue = SBOX[inputValue];

endmodule

// File: rtl/sub_bytes_unit.sv
// Iterative AES SubBytes engine: BYTES_PER_CYCLE S-box lanes sweep a captured
// 128-bit state, then hold the result under a valid/ready output handshake.
module sub_bytes_unit
    import sub_bytes_unit_pkg::*;
#(
    parameter int unsigned BYTES_PER_CYCLE = 4
) (
    input  logic                   clock,
    input  logic                   resetN,
    input  logic                   inValid,
    output logic                   inReady,
    input  logic [AES_STATE_W-1:0] inState,
    output logic                   outValid,
    input  logic                   outReady,
    output logic [AES_STATE_W-1:0] outState,
    output logic                   busy
);

    localparam int unsigned NUM_STEPS = AES_BYTES / BYTES_PER_CYCLE;
    localparam int unsigned CNT_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam int unsigned IDX_W     = $clog2(AES_BYTES);

    if (!legal_bpc(BYTES_PER_CYCLE)) begin : g_bad_bpc
        $error("sub_bytes_unit: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    sub_state_t             state;
    sub_state_t             state_n;
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       count_n;
    aes_block_t             work;
    aes_block_t             work_n;
    logic                   last_step;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic                   busy_q;
    logic [AES_STATE_W-1:0] out_state_q;

    logic [IDX_W-1:0]  lane_pos [BYTES_PER_CYCLE];
    logic [BYTE_W-1:0] lane_in  [BYTES_PER_CYCLE];
    logic [BYTE_W-1:0] lane_out [BYTES_PER_CYCLE];

    assign last_step = (count == CNT_W'(NUM_STEPS - 1));

    // Lane g handles state byte count*BPC+g, which lives at packed index 15-(count*BPC+g).
    for (genvar g = 0; g < int'(BYTES_PER_CYCLE); g++) begin : g_lane
        assign lane_pos[g] = IDX_W'(AES_BYTES - 1 - 32'(g) - 32'(count) * BYTES_PER_CYCLE);
        assign lane_in[g]  = work[lane_pos[g]];

        s_box u_s_box (
            .inputValue  (lane_in[g]),
            .outputValue (lane_out[g])
        );
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        count_n = count;
        work_n  = work;
        unique case (state)
            IDLE: begin
                if (inValid && in_ready_q) begin
                    work_n  = inState;
                    count_n = '0;
                    state_n = SUB;
                end
            end
            SUB: begin
                for (int unsigned i = 0; i < BYTES_PER_CYCLE; i++) begin
                    work_n[lane_pos[i]] = lane_out[i];
                end
                if (last_step) begin
                    count_n = '0;
                    state_n = DONE;
                end else begin
                    count_n = count + 1'b1;
                end
            end
            DONE: begin
                if (outReady) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Handshake flags are registered from the next state so they line up with it.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            count       <= '0;
            work        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_state_q <= '0;
        end else begin
            count       <= count_n;
            work        <= work_n;
            in_ready_q  <= (state_n == IDLE);
            out_valid_q <= (state_n == DONE);
            busy_q      <= (state_n != IDLE);
            if (state == SUB && state_n == DONE) begin
                out_state_q <= work_n;
            end
        end
    end

    assign inReady  = in_ready_q;
    assign outValid = out_valid_q;
    assign busy     = busy_q;
    assign outState = out_state_q;

endmodule

// File: tb/tb_sub_bytes_unit.sv
// Scoreboard bench for sub_bytes_unit: five instances (BPC 1..16) against a
// GF(2^8) inverse + affine reference model, plus a direct S-box check.
module tb_sub_bytes_unit;

    localparam int NI   = 5;
    localparam int MAIN = 2;
    localparam logic [127:0] VEC_IN  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] VEC_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;

    typedef struct {
        int           inst;
        logic [127:0] data;
    } exp_t;

    logic         clock;
    logic         resetN;
    logic         in_valid  [NI];
    logic         in_ready  [NI];
    logic [127:0] in_state  [NI];
    logic         out_valid [NI];
    logic         out_ready [NI];
    logic [127:0] out_state [NI];
    logic         busy      [NI];
    logic [7:0]   sb_in;
    logic [7:0]   sb_out;

    int   checks = 0;
    int   errors = 0;
    int   pops   = 0;
    exp_t exp_q [$];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sub_bytes_unit #(.BYTES_PER_CYCLE(32'(1) << g)) u_dut (
            .clock    (clock),
            .resetN   (resetN),
            .inValid  (in_valid[g]),
            .inReady  (in_ready[g]),
            .inState  (in_state[g]),
            .outValid (out_valid[g]),
            .outReady (out_ready[g]),
            .outState (out_state[g]),
            .busy     (busy[g])
        );
    end

    s_box u_sb (
        .inputValue  (sb_in),
        .outputValue (sb_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_model(input logic [7:0] b);
        logic [7:0] r    = 8'h01;
        logic [7:0] base = b;
        logic [7:0] e    = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[0]) r = gmul(r, base);
            base = gmul(base, base);
            e    = e >> 1;
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] state_model(input logic [127:0] d);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_model(d[8*i +: 8]);
        return r;
    endfunction

    // Pops one expectation per output handshake (handshake completes at the next rising edge).
    always @(negedge clock) begin
        for (int k = 0; k < NI; k++) begin
            if (resetN && out_valid[k] && out_ready[k]) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_unexpected_out", 128'(exp_q.size()), 128'd1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    pops++;
                    check_eq("sb_inst", 128'(k), 128'(e.inst));
                    check_eq("sb_data", out_state[k], e.data);
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the transfer edge.
    task automatic start_block(input int k, input logic [127:0] d, output int waited);
        waited = 0;
        in_valid[k] = 1'b1;
        in_state[k] = d;
        while (!in_ready[k] && waited < 60) begin
            @(posedge clock); #1;
            waited++;
        end
        if (waited >= 60) check_eq("in_ready_timeout", 128'(in_ready[k]), 128'd1);
        exp_q.push_back('{inst: k, data: state_model(d)});
        @(posedge clock); #1;
        in_valid[k] = 1'b0;
        in_state[k] = $urandom();
    endtask

    task automatic wait_out(input int k, output int lat);
        lat = 0;
        while (!out_valid[k] && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int w;
        int p0;
        logic [127:0] held;
        logic [127:0] d;
        logic [15:0] pairs [5];

        resetN = 1'b0;
        sb_in  = 8'h00;
        for (int k = 0; k < NI; k++) begin
            in_valid[k]  = 1'b0;
            in_state[k]  = '0;
            out_ready[k] = 1'b1;
        end

        // Direct S-box lookups
        pairs = '{16'h0063, 16'h53ed, 16'h6c50, 16'h80cd, 16'h5c4a};
        for (int i = 0; i < 5; i++) begin
            sb_in = pairs[i][15:8];
            #1;
            check_eq("sbox_vec", 128'(sb_out), 128'(pairs[i][7:0]));
        end
        for (int i = 0; i < 256; i++) begin
            sb_in = 8'(i);
            #1;
            check_eq("sbox_model", 128'(sb_out), 128'(sbox_model(8'(i))));
        end

        repeat (2) @(posedge clock);
        #1;
        for (int k = 0; k < NI; k++) begin
            check_eq("rst_in_ready", 128'(in_ready[k]), 128'd1);
            check_eq("rst_out_valid", 128'(out_valid[k]), 128'd0);
            check_eq("rst_busy", 128'(busy[k]), 128'd0);
            check_eq("rst_out_state", out_state[k], 128'd0);
        end
        resetN = 1'b1;
        @(posedge clock); #1;

        // Reference vector, BPC=4
        start_block(MAIN, VEC_IN, w);
        wait_out(MAIN, lat);
        check_eq("t2_latency", 128'(lat), 128'd4);
        check_eq("t2_out_state", out_state[MAIN], VEC_OUT);
        @(posedge clock); #1;

        // Backpressure in DONE
        out_ready[MAIN] = 1'b0;
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        start_block(MAIN, d, w);
        wait_out(MAIN, lat);
        check_eq("t3_latency", 128'(lat), 128'd4);
        held = state_model(d);
        p0 = pops;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            check_eq("t3_hold_valid", 128'(out_valid[MAIN]), 128'd1);
            check_eq("t3_hold_state", out_state[MAIN], held);
            check_eq("t3_hold_in_ready", 128'(in_ready[MAIN]), 128'd0);
        end
        out_ready[MAIN] = 1'b1;
        @(posedge clock); #1;
        check_eq("t3_one_pop", 128'(pops - p0), 128'd1);
        check_eq("t3_valid_drop", 128'(out_valid[MAIN]), 128'd0);
        check_eq("t3_in_ready_back", 128'(in_ready[MAIN]), 128'd1);
        check_eq("t3_state_kept", out_state[MAIN], held);

        // Input while busy: second block waits for IDLE
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        start_block(MAIN, d, w);
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        start_block(MAIN, d, w);
        check_eq("t4_wait_cycles", 128'(w), 128'd5);
        wait_out(MAIN, lat);
        check_eq("t4_latency", 128'(lat), 128'd4);
        @(posedge clock); #1;

        // Reset mid-SUB
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        start_block(MAIN, d, w);
        repeat (2) begin
            @(posedge clock); #1;
        end
        check_eq("t5_busy_before", 128'(busy[MAIN]), 128'd1);
        resetN = 1'b0;
        #1;
        check_eq("t5_out_valid", 128'(out_valid[MAIN]), 128'd0);
        check_eq("t5_in_ready", 128'(in_ready[MAIN]), 128'd1);
        check_eq("t5_busy", 128'(busy[MAIN]), 128'd0);
        exp_q.delete();
        @(posedge clock); #1;
        resetN = 1'b1;
        @(posedge clock); #1;
        check_eq("t5_no_output", 128'(out_valid[MAIN]), 128'd0);
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        start_block(MAIN, d, w);
        wait_out(MAIN, lat);
        check_eq("t5_latency", 128'(lat), 128'd4);
        @(posedge clock); #1;

        // Parameter sweep with the reference vector
        for (int k = 0; k < NI; k++) begin
            start_block(k, VEC_IN, w);
            wait_out(k, lat);
            check_eq("t6_latency", 128'(lat), 128'(16 >> k));
            check_eq("t6_out_state", out_state[k], VEC_OUT);
            @(posedge clock); #1;
        end

        // Random blocks on random instances with random backpressure
        for (int r = 0; r < 8; r++) begin
            int k;
            k = int'($urandom_range(0, NI - 1));
            out_ready[k] = 1'($urandom_range(0, 1));
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            start_block(k, d, w);
            wait_out(k, lat);
            check_eq("rnd_latency", 128'(lat), 128'(16 >> k));
            repeat ($urandom_range(0, 4)) begin
                @(posedge clock); #1;
            end
            out_ready[k] = 1'b1;
            @(posedge clock); #1;
        end

        repeat (3) @(posedge clock);
        #1;
        check_eq("sb_drained", 128'(exp_q.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
